data_memory_stage: RTL and testbench
====================================

Name: data_memory_stage

Overview:
- Memory (M) stage of the 5-stage RISC-V pipeline. Sits between the ex_m and m_wb pipeline registers.
- Executes RV32I loads and stores against an internal word-organised data RAM.
- Load data is returned in the following cycle (WB stage), byte-aligned and sign- or zero-extended.
- Detects misaligned, out-of-range and illegal accesses, latches the first fault stickily, and suppresses all stores after a fault.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the data RAM; must be a power of two.
- BASE_ADDR, 32'h0000_1000: byte address of word 0; must be word-aligned.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- valid_m  input  1  M-stage instruction valid
- mem_read_m  input  1  instruction is a load
- mem_write_m  input  1  instruction is a store
- funct3_m  input  3  RV32I width/sign code
- addr_m  input  32  byte address (ALU result, rd_m)
- store_data_m  input  32  rs2 value, already forwarded
- load_data_wb  output  32  extended load result, valid in WB
- load_valid_wb  output  1  load_data_wb holds a completed load
- fault  output  1  sticky: an access fault has occurred
- fault_addr  output  32  addr_m of the first faulting access
- fault_cause  output  2  cause code: 01 misaligned, 10 out of range, 11 illegal
- load_count  output  32  completed loads, wraps at 2^32
- store_count  output  32  completed stores, wraps at 2^32

Behaviour:
- Access request:
  - access = valid_m & (mem_read_m | mem_write_m).
  - Offset = addr_m - BASE_ADDR, computed mod 2^32.
  - Word index = offset[log2(DEPTH_WORDS)+1:2].
  - Out of range when offset >= 4*DEPTH_WORDS.
- Illegal access:
  - mem_read_m & mem_write_m both set.
  - Load with funct3 in {011, 110, 111}.
  - Store with funct3 not in {000, 001, 010}.
- Misaligned access:
  - Half (x01) with addr[0]=1.
  - Word (010) with addr[1:0] != 00.
- Fault cause priority: illegal > misaligned > out of range.
- Faulting access:
  - No RAM write and no load result (load_valid_wb=0 next cycle).
  - If fault=0: set fault, capture fault_addr and fault_cause on the same edge.
  - If fault=1: fault_addr and fault_cause are unchanged.
- Stores (SB=000, SH=001, SW=010):
  - RAM written at the clock edge ending the M cycle.
  - Lane write enables: SB -> lane addr[1:0], data byte [7:0]. SH -> lanes {addr[1],0} and {addr[1],1}, data [15:0]. SW -> all four lanes.
  - Unselected bytes keep their previous value.
  - store_count increments by 1.
- Loads (LB=000, LH=001, LW=010, LBU=100, LHU=101):
  - RAM word read synchronously.
  - funct3 and addr[1:0] registered alongside the read.
  - In the next cycle: lane select, then sign extension (LB/LH) or zero extension (LBU/LHU).
  - load_valid_wb=1 for exactly that one cycle; load_count increments at the M edge.
- Latency:
  - Store is visible to a load issued the next cycle; RAM is write-first across cycles, so no bypass is needed.
  - Load result appears 1 cycle after valid_m.
- Post-fault behaviour: while fault=1, all stores are suppressed and do not count. Loads still execute and count.
- No access (valid_m=0, or both enables low):
  - load_valid_wb=0 next cycle.
  - load_data_wb holds its last value.
  - Counters unchanged.
- Reset:
  - load_data_wb=0, load_valid_wb=0, fault=0, fault_addr=0, fault_cause=00, load_count=0, store_count=0.
  - RAM contents are not reset.
  - A store coincident with rst is not performed.
  - A load in flight at reset produces no load_valid_wb.
- Back-to-back accesses in every cycle are supported. There are no stalls and no ready signal.

Test Plan:
- SW 32'hDEADBEEF to 32'h1000, then LW 32'h1000 next cycle -> load_data_wb=32'hDEADBEEF, load_valid_wb=1 one cycle after the LW, store_count=1, load_count=1.
- SB 32'h000000A5 to 32'h1002 over the word above, then LB 32'h1002 and LBU 32'h1002 -> LB gives 32'hFFFFFFA5, LBU gives 32'h000000A5, LW 32'h1000 gives 32'hDEA5BEEF.
- SH 32'h00008001 to 32'h1006, then LH 32'h1006 and LHU 32'h1006 -> LH gives 32'hFFFF8001, LHU gives 32'h00008001.
- LW 32'h1001 -> fault=1, fault_cause=01, fault_addr=32'h1001, no load_valid_wb. A later SW 32'h55 to 32'h1000 is suppressed: LW 32'h1000 still returns 32'hDEA5BEEF and store_count is unchanged.
- After rst, SW to 32'h0FFC with DEPTH_WORDS=1024 -> fault_cause=10. A following SW to 32'h2000 (also out of range) leaves fault_addr=32'h0FFC.
- Store with funct3=011 -> fault_cause=11. Assert rst in the same cycle as a LW -> all outputs 0 next cycle, load_valid_wb=0, counters 0.

Source files
------------

// File: rtl/data_memory_stage.sv
// Memory stage of the 5-stage RV32I pipeline: executes loads and stores
// against an internal word-organised RAM. Load results are extended in WB.
// The first access fault is latched stickily, and later stores are blocked.
module data_memory_stage #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [2:0]  funct3_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] store_data_m,
    output logic [31:0] load_data_wb,
    output logic        load_valid_wb,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [1:0]  fault_cause,
    output logic [31:0] load_count,
    output logic [31:0] store_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_RANGE      = 2'b10,
        CAUSE_ILLEGAL    = 2'b11
    } cause_e;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             access;
    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic             is_illegal;
    logic             is_misaligned;
    logic             is_out_of_range;
    cause_e           cause_now;
    logic             do_load;
    logic             do_store;
    logic [3:0]       byte_en;
    logic [31:0]      wdata;

    logic [31:0]      rd_word;
    logic [2:0]       ld_funct3;
    logic [1:0]       ld_lane;
    logic             load_valid_q;
    logic             fault_q;
    logic [31:0]      fault_addr_q;
    cause_e           fault_cause_q;
    logic [31:0]      load_count_q;
    logic [31:0]      store_count_q;

    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [31:0]      load_ext;

    // Decode the M-stage request: address translation and fault classification
    always_comb begin
        access   = valid_m & (mem_read_m | mem_write_m);
        offset   = addr_m - BASE_ADDR;
        word_idx = offset[IDX_W+1:2];

        is_illegal = (mem_read_m & mem_write_m)
                   | (mem_read_m  & ((funct3_m == 3'b011) | (funct3_m[2:1] == 2'b11)))
                   | (mem_write_m & (funct3_m[2] | (funct3_m[1:0] == 2'b11)));

        is_misaligned = ((funct3_m[1:0] == 2'b01) & addr_m[0])
                      | ((funct3_m == 3'b010) & (addr_m[1:0] != 2'b00));

        is_out_of_range = ({1'b0, offset} >= SPAN_BYTES);

        if (is_illegal)
            cause_now = CAUSE_ILLEGAL;
        else if (is_misaligned)
            cause_now = CAUSE_MISALIGNED;
        else if (is_out_of_range)
            cause_now = CAUSE_RANGE;
        else
            cause_now = CAUSE_NONE;

        do_load  = access & mem_read_m & (cause_now == CAUSE_NONE);
        do_store = access & mem_write_m & (cause_now == CAUSE_NONE) & ~fault_q & ~rst;
    end

    // Build lane write enables and replicate store data across the lanes
    always_comb begin
        byte_en = 4'b0000;
        wdata   = store_data_m;
        case (funct3_m[1:0])
            2'b00: begin
                byte_en = 4'b0001 << addr_m[1:0];
                wdata   = {4{store_data_m[7:0]}};
            end
            2'b01: begin
                byte_en = addr_m[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{store_data_m[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = store_data_m;
            end
        endcase
    end

    // RAM write port with per-byte lane enables; contents are never reset
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Synchronous read, load/store bookkeeping and sticky fault capture
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word       <= '0;
            ld_funct3     <= '0;
            ld_lane       <= '0;
            load_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
            fault_cause_q <= CAUSE_NONE;
            load_count_q  <= '0;
            store_count_q <= '0;
        end else begin
            load_valid_q <= do_load;
            if (do_load) begin
                rd_word      <= mem[word_idx];
                ld_funct3    <= funct3_m;
                ld_lane      <= addr_m[1:0];
                load_count_q <= load_count_q + 32'd1;
            end
            if (do_store)
                store_count_q <= store_count_q + 32'd1;
            if (access && (cause_now != CAUSE_NONE) && !fault_q) begin
                fault_q       <= 1'b1;
                fault_addr_q  <= addr_m;
                fault_cause_q <= cause_now;
            end
        end
    end

    // WB-side lane select and extension; the read register only changes on a
    // completed load, so the extended result holds between loads
    always_comb begin
        lane_byte = rd_word[8*ld_lane +: 8];
        lane_half = ld_lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (ld_funct3)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'h000000, lane_byte};
            3'b101:  load_ext = {16'h0000, lane_half};
            default: load_ext = rd_word;
        endcase
    end

    assign load_data_wb  = load_ext;
    assign load_valid_wb = load_valid_q;
    assign fault         = fault_q;
    assign fault_addr    = fault_addr_q;
    assign fault_cause   = fault_cause_q;
    assign load_count    = load_count_q;
    assign store_count   = store_count_q;

endmodule

// File: tb/tb_data_memory_stage.sv
// Testbench for data_memory_stage: directed scenarios followed by random
// traffic, all checked against a byte-addressed reference model.
module tb_data_memory_stage;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m;
    logic [31:0] store_data_m;
    logic [31:0] load_data_wb;
    logic        load_valid_wb;
    logic        fault;
    logic [31:0] fault_addr;
    logic [1:0]  fault_cause;
    logic [31:0] load_count;
    logic [31:0] store_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // reference model state
    logic [7:0]  mdl_mem [int unsigned];
    bit          m_fault;
    logic [31:0] m_faddr;
    logic [1:0]  m_fcause;
    logic [31:0] m_lc;
    logic [31:0] m_sc;
    logic [31:0] m_ldata;
    bit          m_lvalid;

    data_memory_stage #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_m      (valid_m),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .funct3_m     (funct3_m),
        .addr_m       (addr_m),
        .store_data_m (store_data_m),
        .load_data_wb (load_data_wb),
        .load_valid_wb(load_valid_wb),
        .fault        (fault),
        .fault_addr   (fault_addr),
        .fault_cause  (fault_cause),
        .load_count   (load_count),
        .store_count  (store_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_byte(input int unsigned k);
        return mdl_mem.exists(k) ? mdl_mem[k] : 8'h00;
    endfunction

    // Apply one request to the model, expressed in terms of access size in bytes
    task automatic model(input bit r, input bit v, input bit rd, input bit wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int unsigned size;
        int unsigned off;
        bit          illegal;
        bit          mis;
        bit          oor;
        logic [1:0]  cause;
        logic [31:0] val;
        if (r) begin
            m_fault = 0; m_faddr = 0; m_fcause = 0;
            m_lc = 0; m_sc = 0; m_ldata = 0; m_lvalid = 0;
            return;
        end
        m_lvalid = 0;
        if (!(v && (rd || wr))) return;
        size    = 1 << f3[1:0];
        illegal = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 > 2);
        mis     = !illegal && ((a % size) != 0);
        off     = a - BASE;
        oor     = off >= 4 * DEPTH;
        cause   = illegal ? 2'd3 : mis ? 2'd1 : oor ? 2'd2 : 2'd0;
        if (cause != 0) begin
            if (!m_fault) begin
                m_fault = 1; m_faddr = a; m_fcause = cause;
            end
        end else if (wr) begin
            if (!m_fault) begin
                for (int unsigned b = 0; b < size; b++)
                    mdl_mem[off + b] = d[8*b +: 8];
                m_sc++;
            end
        end else begin
            val = 0;
            for (int unsigned b = 0; b < size; b++)
                val = val | (32'(rd_byte(off + b)) << (8 * b));
            if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
            if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
            m_ldata  = val;
            m_lvalid = 1;
            m_lc++;
        end
    endtask

    // Drive one cycle of inputs, advance the clock, compare every output
    task automatic step(input bit r, input bit v, input bit rd, input bit wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        rst = r; valid_m = v; mem_read_m = rd; mem_write_m = wr;
        funct3_m = f3; addr_m = a; store_data_m = d;
        model(r, v, rd, wr, f3, a, d);
        @(posedge clk);
        #1;
        check("load_valid_wb", 32'(load_valid_wb), 32'(m_lvalid));
        check("load_data_wb",  load_data_wb, m_ldata);
        check("fault",         32'(fault), 32'(m_fault));
        check("fault_addr",    fault_addr, m_faddr);
        check("fault_cause",   32'(fault_cause), 32'(m_fcause));
        check("load_count",    load_count, m_lc);
        check("store_count",   store_count, m_sc);
    endtask

    task automatic acc(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, rd, wr, f3, a, d);
    endtask

    function automatic logic [31:0] rand_word_addr();
        if ($urandom_range(0, 9) == 0)
            return BASE + 4 * (DEPTH - 1);
        return BASE + 4 * $urandom_range(0, 15);
    endfunction

    task automatic rand_op();
        int unsigned k;
        bit          r;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] bad [4];
        bad[0] = BASE - 4; bad[1] = BASE + 4 * DEPTH; bad[2] = 32'h0; bad[3] = 32'hFFFF_FFFC;
        r = ($urandom_range(0, 99) < 3);
        d = $urandom;
        k = $urandom_range(0, 99);
        if (k < 8) begin
            step(r, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom), rand_word_addr(), d);
        end else if (k < 50) begin
            f3 = 3'($urandom_range(0, 2));
            a  = rand_word_addr() + (f3 == 0 ? $urandom_range(0, 3) : f3 == 1 ? 2 * $urandom_range(0, 1) : 0);
            step(r, 1'b1, 1'b0, 1'b1, f3, a, d);
        end else if (k < 90) begin
            case ($urandom_range(0, 4))
                0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
            endcase
            a = rand_word_addr() + (f3[1:0] == 0 ? $urandom_range(0, 3) : f3[1:0] == 1 ? 2 * $urandom_range(0, 1) : 0);
            step(r, 1'b1, 1'b1, 1'b0, f3, a, d);
        end else if (k < 94) begin
            f3 = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
            a  = rand_word_addr() + (f3 == 3'b010 ? $urandom_range(1, 3) : 1 + 2 * $urandom_range(0, 1));
            step(r, 1'b1, 1'($urandom), 1'($urandom_range(0, 1) == 0), f3, a, d);
        end else if (k < 97) begin
            step(r, 1'b1, 1'($urandom), 1'b1, 3'($urandom_range(0, 2)), bad[$urandom_range(0, 3)], d);
        end else begin
            step(r, 1'b1, 1'($urandom), 1'($urandom), 3'($urandom_range(3, 7)), rand_word_addr(), d);
        end
    endtask

    initial begin
        rst = 1'b1; valid_m = 0; mem_read_m = 0; mem_write_m = 0;
        funct3_m = 0; addr_m = 0; store_data_m = 0;
        @(posedge clk);
        #1;

        // reset state
        step(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
        check("rst_ldata", load_data_wb, 32'h0);
        check("rst_sc", store_count, 32'h0);

        // SW then LW
        acc(0, 1, 3'b010, 32'h1000, 32'hDEADBEEF);
        acc(1, 0, 3'b010, 32'h1000, 32'h0);
        check("lw_data", load_data_wb, 32'hDEADBEEF);
        check("lw_valid", 32'(load_valid_wb), 32'h1);
        check("lw_sc", store_count, 32'd1);
        check("lw_lc", load_count, 32'd1);
        acc(0, 0, 3'b010, 32'h1000, 32'h0);
        check("lw_valid_once", 32'(load_valid_wb), 32'h0);
        check("lw_hold", load_data_wb, 32'hDEADBEEF);

        // SB and byte loads
        acc(0, 1, 3'b000, 32'h1002, 32'h000000A5);
        acc(1, 0, 3'b000, 32'h1002, 32'h0);
        check("lb_data", load_data_wb, 32'hFFFFFFA5);
        acc(1, 0, 3'b100, 32'h1002, 32'h0);
        check("lbu_data", load_data_wb, 32'h000000A5);
        acc(1, 0, 3'b010, 32'h1000, 32'h0);
        check("lw_merge", load_data_wb, 32'hDEA5BEEF);

        // SH and half loads
        acc(0, 1, 3'b001, 32'h1006, 32'h00008001);
        acc(1, 0, 3'b001, 32'h1006, 32'h0);
        check("lh_data", load_data_wb, 32'hFFFF8001);
        acc(1, 0, 3'b101, 32'h1006, 32'h0);
        check("lhu_data", load_data_wb, 32'h00008001);

        // misaligned LW, then suppressed store
        acc(1, 0, 3'b010, 32'h1001, 32'h0);
        check("mis_fault", 32'(fault), 32'h1);
        check("mis_cause", 32'(fault_cause), 32'h1);
        check("mis_addr", fault_addr, 32'h1001);
        check("mis_valid", 32'(load_valid_wb), 32'h0);
        acc(0, 1, 3'b010, 32'h1000, 32'h55);
        acc(1, 0, 3'b010, 32'h1000, 32'h0);
        check("supp_data", load_data_wb, 32'hDEA5BEEF);
        check("supp_sc", store_count, 32'd3);

        // out-of-range below and above the RAM window
        step(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
        acc(0, 1, 3'b010, 32'h0FFC, 32'h1234);
        check("oor_cause", 32'(fault_cause), 32'h2);
        acc(0, 1, 3'b010, 32'h2000, 32'h1234);
        check("oor_addr", fault_addr, 32'h0FFC);

        // illegal store width, then reset during a load
        step(1, 0, 0, 0, 3'b000, 32'h0, 32'h0);
        acc(0, 1, 3'b011, 32'h1000, 32'h0);
        check("ill_cause", 32'(fault_cause), 32'h3);
        acc(1, 0, 3'b010, 32'h1000, 32'h0);
        step(1, 1, 1, 0, 3'b010, 32'h1000, 32'h0);
        check("rst_ld_valid", 32'(load_valid_wb), 32'h0);
        check("rst_ld_lc", load_count, 32'h0);
        check("rst_ld_fault", 32'(fault), 32'h0);

        // random traffic over an initialised window plus the last RAM word
        for (int unsigned w = 0; w < 16; w++)
            acc(0, 1, 3'b010, BASE + 4 * w, $urandom);
        acc(0, 1, 3'b010, BASE + 4 * (DEPTH - 1), $urandom);
        for (int unsigned n = 0; n < 1500; n++)
            rand_op();

        step(0, 0, 0, 0, 3'b000, 32'h0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
